// File: rtl/arb_pkg.sv
// Shared constants and state encoding for the four-way round-robin arbiter.
package arb_pkg;

   localparam int NUM_REQ = 4;
   localparam int IDX_W   = 2;

   // Arbiter FSM states; IDLE also serves as the dead cycle between owners.
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

endpackage : arb_pkg

// File: rtl/grant_decode_2to4.sv
// Enable-gated 2-to-4 decoder turning the registered grant index into a one-hot vector.
module grant_decode_2to4
   import arb_pkg::*;
(
   input  logic             en,
   input  logic [IDX_W-1:0] idx,
   output logic [3:0]       onehot
);

   // One-hot decode of idx, forced to zero when no grant is active.
   always_comb begin
      onehot = 4'b0000;
      if (en) begin
         case (idx)
            2'd0:    onehot = 4'b0001;
            2'd1:    onehot = 4'b0010;
            2'd2:    onehot = 4'b0100;
            2'd3:    onehot = 4'b1000;
            default: onehot = 4'b0000;
         endcase
      end else begin
         onehot = 4'b0000;
      end
   end

endmodule : grant_decode_2to4

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a hold limit that forces rotation
// under contention. Grant index/valid are registered; the one-hot grant is
// decoded from those registers only, so req never reaches gnt combinationally.
module rr_arbiter_4
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
)(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   output logic [NUM_REQ-1:0]   gnt,
   output logic                 gnt_valid,
   output logic [IDX_W-1:0]     gnt_idx
);

   // Hold limit is compared in the counter's own width.
   localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD - 1);

   arb_state_e        state_q;
   logic              gnt_valid_q;
   logic [IDX_W-1:0]  gnt_idx_q;
   logic [IDX_W-1:0]  ptr_q;
   logic [CNT_W-1:0]  hold_cnt_q;

   logic              owner_req;
   logic              other_req;
   logic              hold_at_lim;

   // First requester found searching ptr, ptr+1, ... with wrap-around.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [IDX_W-1:0]   p);
      logic [IDX_W-1:0] cand;
      logic             found;
      rr_pick = p;
      found   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = p + IDX_W'(i);
         if (!found && r[cand]) begin
            rr_pick = cand;
            found   = 1'b1;
         end else begin
            found   = found;
         end
      end
   endfunction

   // Qualifiers for the GRANT state, all derived from current registers and req.
   always_comb begin
      owner_req   = req[gnt_idx_q];
      other_req   = |(req & ~gnt);
      hold_at_lim = (hold_cnt_q == HOLD_LIM);
   end

   // Arbiter FSM: grant on request, release on drop or hold-limit preempt.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         gnt_valid_q <= 1'b0;
         gnt_idx_q   <= {IDX_W{1'b0}};
         ptr_q       <= {IDX_W{1'b0}};
         hold_cnt_q  <= {CNT_W{1'b0}};
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req != {NUM_REQ{1'b0}}) begin
                  gnt_idx_q   <= rr_pick(req, ptr_q);
                  gnt_valid_q <= 1'b1;
                  hold_cnt_q  <= {CNT_W{1'b0}};
                  state_q     <= ST_GRANT;
               end else begin
                  gnt_valid_q <= 1'b0;
               end
            end
            ST_GRANT: begin
               if (!owner_req || (other_req && hold_at_lim)) begin
                  // Release or preempt: one dead cycle, then search after the owner.
                  gnt_valid_q <= 1'b0;
                  ptr_q       <= gnt_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                  hold_cnt_q  <= {CNT_W{1'b0}};
                  state_q     <= ST_IDLE;
               end else if (!hold_at_lim) begin
                  hold_cnt_q  <= hold_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               end else begin
                  // Alone at the limit: stay saturated, keep the grant.
                  hold_cnt_q  <= hold_cnt_q;
               end
            end
            default: begin
               state_q     <= ST_IDLE;
               gnt_valid_q <= 1'b0;
            end
         endcase
      end
   end

   grant_decode_2to4 u_dec (
      .en     (gnt_valid_q),
      .idx    (gnt_idx_q),
      .onehot (gnt)
   );

   assign gnt_valid = gnt_valid_q;
   assign gnt_idx   = gnt_idx_q;

endmodule : rr_arbiter_4

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource, such as a bus or functional unit, between four masters.
- Grant index and grant-valid are registered.
- The one-hot grant vector comes from a 2-to-4 enable-gated decoder on those registers.
- A hold limit forces rotation so a greedy requester cannot starve the others.

Parameters:
- MAX_HOLD, 8, max consecutive grant cycles for one requester while another requester is waiting; legal range 1..2**CNT_W.
- CNT_W, 4, width of the hold counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector; req[i] high = requester i wants the resource.
- gnt  output  4  one-hot grant; all zero when idle.
- gnt_valid  output  1  a grant is active this cycle.
- gnt_idx  output  2  index of the granted requester; valid only when gnt_valid=1.

Behaviour:
- Reset (async, immediate, no clock edge needed):
  - state=IDLE, gnt_valid=0, gnt_idx=0, gnt=4'b0000.
  - Priority pointer ptr=0; hold_cnt=0.
- States: IDLE, GRANT. Encoding: IDLE=0, GRANT=1.
- IDLE, req==0: stay; outputs unchanged at zero.
- IDLE, req!=0:
  - Select the first set bit searching ptr, ptr+1, ... mod 4.
  - At that edge: gnt_idx<=selected, gnt_valid<=1, hold_cnt<=0, state<=GRANT.
  - Latency: req seen at edge N gives gnt asserted after edge N (1 cycle).
- GRANT, req[gnt_idx]==0 (release):
  - At the edge: gnt_valid<=0, ptr<=gnt_idx+1 mod 4, state<=IDLE.
  - gnt drops one cycle after req drops.
- GRANT, req[gnt_idx]==1 and (req & ~gnt)==0 (no other requester):
  - Keep grant.
  - hold_cnt increments, saturating at MAX_HOLD-1.
  - No forced release.
- GRANT, req[gnt_idx]==1, another request pending, hold_cnt==MAX_HOLD-1 (preempt):
  - Same action as release: gnt_valid<=0, ptr<=gnt_idx+1, state<=IDLE.
  - Grant duration is exactly MAX_HOLD cycles.
- GRANT, other cases: hold_cnt<=hold_cnt+1; grant held.
- Every release or preempt inserts exactly one dead cycle (gnt=0) before the next grant, so ownership handoff never overlaps.
- MAX_HOLD=1: a contended requester gets 1 cycle on, then 1 dead cycle.
- ptr wraps 3->0. Wrap-around search: ptr=3 with req=4'b0011 grants 0.
- Requests changing while in GRANT do not affect gnt_idx. Only release or preempt re-arbitrate.
- Reset asserted mid-grant: gnt clears asynchronously. After reset deasserts, arbitration restarts from ptr=0.
- gnt is purely combinational from registers: gnt[i] = gnt_valid & (gnt_idx==i). No combinational path from req to gnt.
- Counter width: hold_cnt is CNT_W bits, compared against MAX_HOLD-1 truncated to CNT_W.

Decomposition:
- Shared package/header arb_pkg holds:
  - NUM_REQ=4, IDX_W=2.
  - State encodings ST_IDLE=1'b0, ST_GRANT=1'b1.
- One sub-module, grant_decode_2to4: inputs en, idx[1:0]; output one-hot[3:0].
  - Instantiated with en=gnt_valid, idx=gnt_idx.
- Round-robin next-index search is a function inside rr_arbiter_4, not a separate module.

Test Plan:
1. Reset, then req=4'b0100 for 3 cycles, then 0:
   - gnt=4'b0100 and gnt_idx=2 from the cycle after req rises, for 3 cycles.
   - gnt=0 the cycle after req falls.
   - A following req=4'b1111 grants index 3 (ptr=3).
2. MAX_HOLD=2, req=4'b1111 constant:
   - Grant sequence 0,0,-,1,1,-,2,2,-,3,3,-,0 (- = dead cycle, gnt=0).
   - gnt_valid matches.
3. Wrap: after grant to 3 is released, req=4'b1001 -> next grant is index 0, not 3.
4. MAX_HOLD=2, req=4'b0010 held 20 cycles alone -> gnt=4'b0010 continuous 20 cycles, no dead cycle.
   - Raising req[0] at cycle 20 -> gnt drops after 1 more cycle (hold_cnt saturated); req[0] granted after the dead cycle.
5. Async reset pulse mid-grant (idx=1), between clock edges:
   - gnt, gnt_valid go to 0 immediately with no clock edge.
   - After release with req=4'b1010 -> grant index 1 (ptr=0 search finds 1 first).
6. One-cycle pulse req=4'b1000 -> gnt=4'b1000 for exactly 1 cycle, then gnt=0; ptr=0.
